// File: rtl/coreriscv_axi4_tl_uncached_scratchpad_manager_pkg.sv
// Shared TileLink encodings, field geometry and FSM state type for the uncached
// scratchpad manager.
package coreriscv_axi4_tl_uncached_scratchpad_manager_pkg;

  localparam int DATA_W          = 64;
  localparam int BE_W            = DATA_W / 8;
  localparam int BEATS_PER_BLOCK = 8;
  localparam int BEAT_W          = 3;
  localparam int XID_W           = 2;
  localparam int ADDR_BLOCK_W    = 26;
  localparam int UNION_W         = 12;
  localparam int WMASK_LSB       = 1;
  localparam int WMASK_W         = 8;
  localparam int A_TYPE_W        = 3;
  localparam int G_TYPE_W        = 4;

  localparam logic [A_TYPE_W-1:0] A_GET       = 3'd0;
  localparam logic [A_TYPE_W-1:0] A_GET_BLOCK = 3'd1;
  localparam logic [A_TYPE_W-1:0] A_PUT       = 3'd2;
  localparam logic [A_TYPE_W-1:0] A_PUT_BLOCK = 3'd3;

  localparam logic [G_TYPE_W-1:0] G_PUT_ACK        = 4'd2;
  localparam logic [G_TYPE_W-1:0] G_GET_DATA_BEAT  = 4'd3;
  localparam logic [G_TYPE_W-1:0] G_GET_DATA_BLOCK = 4'd4;

  localparam logic [BEAT_W-1:0] LAST_BEAT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_ISSUE   = 3'd1,
    ST_GRANT_DATA = 3'd2,
    ST_PUT_BLK    = 3'd3,
    ST_GRANT_ACK  = 3'd4
  } state_e;

  function automatic logic [WMASK_W-1:0] union_wmask(input logic [UNION_W-1:0] u);
    return u[WMASK_LSB +: WMASK_W];
  endfunction

  function automatic logic is_supported(input logic builtin, input logic [A_TYPE_W-1:0] a_type);
    return builtin && (a_type <= A_PUT_BLOCK);
  endfunction

endpackage

// File: rtl/coreriscv_axi4_tl_scratchpad_ram.sv
// Single-port 64-bit scratchpad: byte-enabled write, registered 1-cycle read.
// The read register can be cleared so acks present zero data.
module coreriscv_axi4_tl_scratchpad_ram
  import coreriscv_axi4_tl_uncached_scratchpad_manager_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_clr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [1 << ADDR_W];
  logic [DATA_W-1:0] rdata_r;

  // Byte-enabled write into the array (contents intentionally not reset)
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) begin
          mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read port; holds its value until the next read or clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (en && !we) begin
      rdata_r <= mem_r[addr];
    end else if (rd_clr) begin
      rdata_r <= {DATA_W{1'b0}};
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/coreriscv_axi4_tl_uncached_scratchpad_manager.sv
// TileLink uncached manager fronting an on-chip scratchpad: serves Get, GetBlock,
// Put and PutBlock, one transaction at a time.
module coreriscv_axi4_tl_uncached_scratchpad_manager
  import coreriscv_axi4_tl_uncached_scratchpad_manager_pkg::*;
#(
  parameter int BLOCKS_LOG2 = 7
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    io_acquire_ready,
  input  logic                    io_acquire_valid,
  input  logic [ADDR_BLOCK_W-1:0] io_acquire_bits_addr_block,
  input  logic [XID_W-1:0]        io_acquire_bits_client_xact_id,
  input  logic [BEAT_W-1:0]       io_acquire_bits_addr_beat,
  input  logic                    io_acquire_bits_is_builtin_type,
  input  logic [A_TYPE_W-1:0]     io_acquire_bits_a_type,
  input  logic [UNION_W-1:0]      io_acquire_bits_union,
  input  logic [DATA_W-1:0]       io_acquire_bits_data,
  input  logic                    io_grant_ready,
  output logic                    io_grant_valid,
  output logic [BEAT_W-1:0]       io_grant_bits_addr_beat,
  output logic [XID_W-1:0]        io_grant_bits_client_xact_id,
  output logic                    io_grant_bits_manager_xact_id,
  output logic                    io_grant_bits_is_builtin_type,
  output logic [G_TYPE_W-1:0]     io_grant_bits_g_type,
  output logic [DATA_W-1:0]       io_grant_bits_data,
  output logic                    err_unsupported
);

  localparam int WORD_AW = BLOCKS_LOG2 + BEAT_W;

  state_e                 state_r, state_nxt_s;
  logic [BEAT_W-1:0]      cnt_r, cnt_nxt_s;
  logic [XID_W-1:0]       xid_r, xid_nxt_s;
  logic [A_TYPE_W-1:0]    atype_r, atype_nxt_s;
  logic [BLOCKS_LOG2-1:0] blk_r, blk_nxt_s;
  logic                   gv_r, gv_nxt_s;
  logic [BEAT_W-1:0]      gbeat_r, gbeat_nxt_s;
  logic [G_TYPE_W-1:0]    gtype_r, gtype_nxt_s;
  logic                   err_r, err_set_s;

  logic                   acq_ready_s, acq_fire_s, grant_fire_s, pb_beat_ok_s;
  logic [BLOCKS_LOG2-1:0] acq_blk_s;
  logic                   ram_en_s, ram_we_s, ram_rd_clr_s;
  logic [WORD_AW-1:0]     ram_addr_s;
  logic [DATA_W-1:0]      ram_rdata_s;
  logic                   unused_s;

  assign acq_blk_s    = io_acquire_bits_addr_block[BLOCKS_LOG2-1:0];
  assign acq_ready_s  = (state_r == ST_IDLE) || (state_r == ST_PUT_BLK);
  assign acq_fire_s   = io_acquire_valid && acq_ready_s;
  assign grant_fire_s = gv_r && io_grant_ready;
  // Follow-on PutBlock beats must belong to the same transaction to be written
  assign pb_beat_ok_s = io_acquire_bits_is_builtin_type && (io_acquire_bits_a_type == A_PUT_BLOCK)
                        && (io_acquire_bits_client_xact_id == xid_r);
  assign unused_s     = ^{io_acquire_bits_addr_block[ADDR_BLOCK_W-1:BLOCKS_LOG2],
                          io_acquire_bits_union[UNION_W-1:WMASK_LSB+WMASK_W],
                          io_acquire_bits_union[WMASK_LSB-1:0]};

  // Next-state, RAM control and next grant register values
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    xid_nxt_s    = xid_r;
    atype_nxt_s  = atype_r;
    blk_nxt_s    = blk_r;
    gv_nxt_s     = gv_r;
    gbeat_nxt_s  = gbeat_r;
    gtype_nxt_s  = gtype_r;
    err_set_s    = 1'b0;
    ram_en_s     = 1'b0;
    ram_we_s     = 1'b0;
    ram_rd_clr_s = 1'b0;
    ram_addr_s   = {acq_blk_s, io_acquire_bits_addr_beat};
    case (state_r)
      ST_IDLE: begin
        if (acq_fire_s) begin
          xid_nxt_s   = io_acquire_bits_client_xact_id;
          atype_nxt_s = io_acquire_bits_a_type;
          blk_nxt_s   = acq_blk_s;
          if (!is_supported(io_acquire_bits_is_builtin_type, io_acquire_bits_a_type)) begin
            err_set_s    = 1'b1;
            ram_rd_clr_s = 1'b1;
            state_nxt_s  = ST_GRANT_ACK;
            gv_nxt_s     = 1'b1;
            gtype_nxt_s  = G_PUT_ACK;
            gbeat_nxt_s  = 3'd0;
          end else if (io_acquire_bits_a_type == A_GET) begin
            ram_en_s    = 1'b1;
            state_nxt_s = ST_GRANT_DATA;
            gv_nxt_s    = 1'b1;
            gtype_nxt_s = G_GET_DATA_BEAT;
            gbeat_nxt_s = io_acquire_bits_addr_beat;
          end else if (io_acquire_bits_a_type == A_GET_BLOCK) begin
            ram_en_s    = 1'b1;
            ram_addr_s  = {acq_blk_s, 3'd0};
            cnt_nxt_s   = 3'd0;
            state_nxt_s = ST_GRANT_DATA;
            gv_nxt_s    = 1'b1;
            gtype_nxt_s = G_GET_DATA_BLOCK;
            gbeat_nxt_s = 3'd0;
          end else if (io_acquire_bits_a_type == A_PUT) begin
            ram_en_s     = 1'b1;
            ram_we_s     = 1'b1;
            ram_rd_clr_s = 1'b1;
            state_nxt_s  = ST_GRANT_ACK;
            gv_nxt_s     = 1'b1;
            gtype_nxt_s  = G_PUT_ACK;
            gbeat_nxt_s  = 3'd0;
          end else begin
            ram_en_s    = 1'b1;
            ram_we_s    = 1'b1;
            cnt_nxt_s   = 3'd1;
            state_nxt_s = ST_PUT_BLK;
          end
        end else begin
          gv_nxt_s = 1'b0;
        end
      end
      ST_GRANT_DATA: begin
        if (grant_fire_s && (atype_r == A_GET_BLOCK) && (cnt_r != LAST_BEAT)) begin
          cnt_nxt_s   = cnt_r + 3'd1;
          ram_en_s    = 1'b1;
          ram_addr_s  = {blk_r, cnt_r + 3'd1};
          state_nxt_s = ST_RD_ISSUE;
          gv_nxt_s    = 1'b0;
        end else if (grant_fire_s) begin
          cnt_nxt_s   = 3'd0;
          state_nxt_s = ST_IDLE;
          gv_nxt_s    = 1'b0;
        end else begin
          gv_nxt_s = 1'b1;
        end
      end
      ST_RD_ISSUE: begin
        state_nxt_s = ST_GRANT_DATA;
        gv_nxt_s    = 1'b1;
        gbeat_nxt_s = cnt_r;
      end
      ST_PUT_BLK: begin
        if (acq_fire_s) begin
          cnt_nxt_s = cnt_r + 3'd1;
          ram_en_s  = pb_beat_ok_s;
          ram_we_s  = pb_beat_ok_s;
          err_set_s = !pb_beat_ok_s;
          if (cnt_r == LAST_BEAT) begin
            ram_rd_clr_s = 1'b1;
            state_nxt_s  = ST_GRANT_ACK;
            gv_nxt_s     = 1'b1;
            gtype_nxt_s  = G_PUT_ACK;
            gbeat_nxt_s  = 3'd0;
          end else begin
            state_nxt_s = ST_PUT_BLK;
          end
        end else begin
          state_nxt_s = ST_PUT_BLK;
        end
      end
      ST_GRANT_ACK: begin
        if (grant_fire_s) begin
          state_nxt_s = ST_IDLE;
          gv_nxt_s    = 1'b0;
        end else begin
          gv_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gv_nxt_s    = 1'b0;
      end
    endcase
  end

  // State, transaction latch, grant output registers and sticky error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      xid_r   <= 2'd0;
      atype_r <= 3'd0;
      blk_r   <= {BLOCKS_LOG2{1'b0}};
      gv_r    <= 1'b0;
      gbeat_r <= 3'd0;
      gtype_r <= 4'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      xid_r   <= xid_nxt_s;
      atype_r <= atype_nxt_s;
      blk_r   <= blk_nxt_s;
      gv_r    <= gv_nxt_s;
      gbeat_r <= gbeat_nxt_s;
      gtype_r <= gtype_nxt_s;
      err_r   <= err_r | err_set_s;
    end
  end

  coreriscv_axi4_tl_scratchpad_ram #(
    .ADDR_W (WORD_AW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (reset_n),
    .en     (ram_en_s),
    .we     (ram_we_s),
    .addr   (ram_addr_s),
    .be     (union_wmask(io_acquire_bits_union)),
    .wdata  (io_acquire_bits_data),
    .rd_clr (ram_rd_clr_s),
    .rdata  (ram_rdata_s)
  );

  assign io_acquire_ready              = acq_ready_s;
  assign io_grant_valid                = gv_r;
  assign io_grant_bits_addr_beat       = gbeat_r;
  assign io_grant_bits_client_xact_id  = xid_r;
  assign io_grant_bits_manager_xact_id = 1'b0;
  assign io_grant_bits_is_builtin_type = 1'b1;
  assign io_grant_bits_g_type          = gtype_r;
  assign io_grant_bits_data            = ram_rdata_s;
  assign err_unsupported               = err_r;

endmodule

// File: tb/tb_coreriscv_axi4_tl_uncached_scratchpad_manager.sv
// Directed self-checking bench for the uncached TileLink scratchpad manager.
module tb_coreriscv_axi4_tl_uncached_scratchpad_manager;

  localparam logic [63:0] STEP = 64'h0101010101010101;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        io_acquire_ready;
  logic        io_acquire_valid = 1'b0;
  logic [25:0] io_acquire_bits_addr_block = 26'd0;
  logic [1:0]  io_acquire_bits_client_xact_id = 2'd0;
  logic [2:0]  io_acquire_bits_addr_beat = 3'd0;
  logic        io_acquire_bits_is_builtin_type = 1'b1;
  logic [2:0]  io_acquire_bits_a_type = 3'd0;
  logic [11:0] io_acquire_bits_union = 12'd0;
  logic [63:0] io_acquire_bits_data = 64'd0;
  logic        io_grant_ready = 1'b0;
  logic        io_grant_valid;
  logic [2:0]  io_grant_bits_addr_beat;
  logic [1:0]  io_grant_bits_client_xact_id;
  logic        io_grant_bits_manager_xact_id;
  logic        io_grant_bits_is_builtin_type;
  logic [3:0]  io_grant_bits_g_type;
  logic [63:0] io_grant_bits_data;
  logic        err_unsupported;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  coreriscv_axi4_tl_uncached_scratchpad_manager #(.BLOCKS_LOG2(7)) dut (
    .clk                             (clk),
    .reset_n                         (reset_n),
    .io_acquire_ready                (io_acquire_ready),
    .io_acquire_valid                (io_acquire_valid),
    .io_acquire_bits_addr_block      (io_acquire_bits_addr_block),
    .io_acquire_bits_client_xact_id  (io_acquire_bits_client_xact_id),
    .io_acquire_bits_addr_beat       (io_acquire_bits_addr_beat),
    .io_acquire_bits_is_builtin_type (io_acquire_bits_is_builtin_type),
    .io_acquire_bits_a_type          (io_acquire_bits_a_type),
    .io_acquire_bits_union           (io_acquire_bits_union),
    .io_acquire_bits_data            (io_acquire_bits_data),
    .io_grant_ready                  (io_grant_ready),
    .io_grant_valid                  (io_grant_valid),
    .io_grant_bits_addr_beat         (io_grant_bits_addr_beat),
    .io_grant_bits_client_xact_id    (io_grant_bits_client_xact_id),
    .io_grant_bits_manager_xact_id   (io_grant_bits_manager_xact_id),
    .io_grant_bits_is_builtin_type   (io_grant_bits_is_builtin_type),
    .io_grant_bits_g_type            (io_grant_bits_g_type),
    .io_grant_bits_data              (io_grant_bits_data),
    .err_unsupported                 (err_unsupported)
  );

  task automatic send_acq(input logic [25:0] blk, input logic [2:0] beat, input logic [1:0] xid,
                          input logic builtin, input logic [2:0] atype, input logic [7:0] wm,
                          input logic [63:0] data);
    int n;
    @(negedge clk);
    io_acquire_valid                = 1'b1;
    io_acquire_bits_addr_block      = blk;
    io_acquire_bits_addr_beat       = beat;
    io_acquire_bits_client_xact_id  = xid;
    io_acquire_bits_is_builtin_type = builtin;
    io_acquire_bits_a_type          = atype;
    io_acquire_bits_union           = {3'b000, wm, 1'b0};
    io_acquire_bits_data            = data;
    n = 0;
    while (!io_acquire_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!io_acquire_ready) begin
      chk_cnt++;
      $display("FAIL acquire_ready_timeout got 0 expected 1");
    end
    @(posedge clk);
    #1;
    io_acquire_valid = 1'b0;
  endtask

  task automatic wait_gv();
    int n;
    n = 0;
    @(negedge clk);
    while (!io_grant_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!io_grant_valid) begin
      chk_cnt++;
      $display("FAIL grant_valid_timeout got 0 expected 1");
    end
  endtask

  task automatic pop_grant();
    io_grant_ready = 1'b1;
    @(posedge clk);
    #1;
    io_grant_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (io_grant_valid !== 1'b0) $display("FAIL rst_grant_valid got %b expected 0", io_grant_valid); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_g_type !== 4'd0) $display("FAIL rst_g_type got %0d expected 0", io_grant_bits_g_type); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_data !== 64'd0) $display("FAIL rst_data got %h expected 0", io_grant_bits_data); else pass_cnt++;
    chk_cnt++; if (err_unsupported !== 1'b0) $display("FAIL rst_err got %b expected 0", err_unsupported); else pass_cnt++;
    chk_cnt++; if (io_acquire_ready !== 1'b1) $display("FAIL rst_acq_ready got %b expected 1", io_acquire_ready); else pass_cnt++;
    reset_n = 1'b1;
  endtask

  task automatic test_put_get();
    send_acq(26'd5, 3'd2, 2'd2, 1'b1, 3'd2, 8'hFF, 64'h1122334455667788);
    @(negedge clk);
    chk_cnt++; if (io_grant_valid !== 1'b1) $display("FAIL put_ack_latency got %b expected 1", io_grant_valid); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_g_type !== 4'd2) $display("FAIL put_ack_gtype got %0d expected 2", io_grant_bits_g_type); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_client_xact_id !== 2'd2) $display("FAIL put_ack_xid got %0d expected 2", io_grant_bits_client_xact_id); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_data !== 64'd0) $display("FAIL put_ack_data got %h expected 0", io_grant_bits_data); else pass_cnt++;
    pop_grant();
    send_acq(26'd5, 3'd2, 2'd1, 1'b1, 3'd0, 8'h00, 64'd0);
    @(negedge clk);
    chk_cnt++; if (io_grant_valid !== 1'b1) $display("FAIL get_latency got %b expected 1", io_grant_valid); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_g_type !== 4'd3) $display("FAIL get_gtype got %0d expected 3", io_grant_bits_g_type); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_addr_beat !== 3'd2) $display("FAIL get_beat got %0d expected 2", io_grant_bits_addr_beat); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_client_xact_id !== 2'd1) $display("FAIL get_xid got %0d expected 1", io_grant_bits_client_xact_id); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_data !== 64'h1122334455667788) $display("FAIL get_data got %h expected 1122334455667788", io_grant_bits_data); else pass_cnt++;
    pop_grant();
  endtask

  task automatic test_partial_put();
    send_acq(26'd5, 3'd2, 2'd0, 1'b1, 3'd2, 8'h0F, 64'hFFFFFFFFFFFFFFFF);
    wait_gv();
    pop_grant();
    send_acq(26'd5, 3'd2, 2'd0, 1'b1, 3'd0, 8'h00, 64'd0);
    wait_gv();
    chk_cnt++; if (io_grant_bits_data !== 64'h11223344FFFFFFFF) $display("FAIL partial_put_data got %h expected 11223344ffffffff", io_grant_bits_data); else pass_cnt++;
    pop_grant();
  endtask

  task automatic test_put_block();
    logic early_gv;
    early_gv = 1'b0;
    for (int b = 0; b < 8; b++) begin
      send_acq(26'd3, 3'(b), 2'd3, 1'b1, 3'd3, 8'hFF, 64'(b) * STEP);
      if (b < 7) begin
        @(negedge clk);
        if (io_grant_valid) early_gv = 1'b1;
      end
    end
    chk_cnt++; if (early_gv !== 1'b0) $display("FAIL putblk_early_grant got %b expected 0", early_gv); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (io_grant_valid !== 1'b1) $display("FAIL putblk_ack_valid got %b expected 1", io_grant_valid); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_g_type !== 4'd2) $display("FAIL putblk_ack_gtype got %0d expected 2", io_grant_bits_g_type); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_client_xact_id !== 2'd3) $display("FAIL putblk_ack_xid got %0d expected 3", io_grant_bits_client_xact_id); else pass_cnt++;
    pop_grant();
    early_gv = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (io_grant_valid) early_gv = 1'b1;
    end
    chk_cnt++; if (early_gv !== 1'b0) $display("FAIL putblk_extra_ack got %b expected 0", early_gv); else pass_cnt++;
  endtask

  task automatic test_get_block();
    logic [63:0] held;
    logic        extra;
    send_acq(26'd3, 3'd5, 2'd0, 1'b1, 3'd1, 8'h00, 64'd0);
    for (int b = 0; b < 8; b++) begin
      wait_gv();
      chk_cnt++; if (io_grant_bits_addr_beat !== 3'(b)) $display("FAIL getblk_beat got %0d expected %0d", io_grant_bits_addr_beat, b); else pass_cnt++;
      chk_cnt++; if (io_grant_bits_g_type !== 4'd4) $display("FAIL getblk_gtype got %0d expected 4", io_grant_bits_g_type); else pass_cnt++;
      chk_cnt++; if (io_grant_bits_data !== 64'(b) * STEP) $display("FAIL getblk_data beat %0d got %h expected %h", b, io_grant_bits_data, 64'(b) * STEP); else pass_cnt++;
      if (b % 2 == 0) begin
        held = 64'(b) * STEP;
        repeat (2) @(negedge clk);
        chk_cnt++; if (io_grant_valid !== 1'b1) $display("FAIL getblk_stall_valid got %b expected 1", io_grant_valid); else pass_cnt++;
        chk_cnt++; if (io_grant_bits_data !== held) $display("FAIL getblk_stall_data got %h expected %h", io_grant_bits_data, held); else pass_cnt++;
      end
      pop_grant();
    end
    extra = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (io_grant_valid) extra = 1'b1;
    end
    chk_cnt++; if (extra !== 1'b0) $display("FAIL getblk_extra_beat got %b expected 0", extra); else pass_cnt++;
  endtask

  task automatic test_unsupported();
    send_acq(26'd5, 3'd2, 2'd1, 1'b1, 3'd4, 8'hFF, 64'd0);
    @(negedge clk);
    chk_cnt++; if (io_acquire_ready !== 1'b0) $display("FAIL unsup_acq_ready got %b expected 0", io_acquire_ready); else pass_cnt++;
    chk_cnt++; if (err_unsupported !== 1'b1) $display("FAIL unsup_err got %b expected 1", err_unsupported); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_g_type !== 4'd2) $display("FAIL unsup_gtype got %0d expected 2", io_grant_bits_g_type); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_client_xact_id !== 2'd1) $display("FAIL unsup_xid got %0d expected 1", io_grant_bits_client_xact_id); else pass_cnt++;
    repeat (2) @(negedge clk);
    chk_cnt++; if (io_acquire_ready !== 1'b0) $display("FAIL unsup_acq_ready_stall got %b expected 0", io_acquire_ready); else pass_cnt++;
    pop_grant();
    @(negedge clk);
    chk_cnt++; if (io_acquire_ready !== 1'b1) $display("FAIL unsup_acq_ready_after got %b expected 1", io_acquire_ready); else pass_cnt++;
    send_acq(26'd5, 3'd2, 2'd0, 1'b1, 3'd0, 8'h00, 64'd0);
    wait_gv();
    chk_cnt++; if (io_grant_bits_data !== 64'h11223344FFFFFFFF) $display("FAIL unsup_ram_changed got %h expected 11223344ffffffff", io_grant_bits_data); else pass_cnt++;
    chk_cnt++; if (err_unsupported !== 1'b1) $display("FAIL unsup_err_sticky got %b expected 1", err_unsupported); else pass_cnt++;
    pop_grant();
  endtask

  task automatic test_reset_mid();
    send_acq(26'd3, 3'd0, 2'd2, 1'b1, 3'd1, 8'h00, 64'd0);
    for (int b = 0; b < 4; b++) begin
      wait_gv();
      pop_grant();
    end
    wait_gv();
    chk_cnt++; if (io_grant_bits_addr_beat !== 3'd4) $display("FAIL midrst_beat got %0d expected 4", io_grant_bits_addr_beat); else pass_cnt++;
    #1 reset_n = 1'b0;
    #1;
    chk_cnt++; if (io_grant_valid !== 1'b0) $display("FAIL midrst_valid got %b expected 0", io_grant_valid); else pass_cnt++;
    chk_cnt++; if (io_acquire_ready !== 1'b1) $display("FAIL midrst_idle got %b expected 1", io_acquire_ready); else pass_cnt++;
    chk_cnt++; if (err_unsupported !== 1'b0) $display("FAIL midrst_err got %b expected 0", err_unsupported); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    send_acq(26'd3, 3'd6, 2'd3, 1'b1, 3'd0, 8'h00, 64'd0);
    @(negedge clk);
    chk_cnt++; if (io_grant_valid !== 1'b1) $display("FAIL postrst_valid got %b expected 1", io_grant_valid); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_g_type !== 4'd3) $display("FAIL postrst_gtype got %0d expected 3", io_grant_bits_g_type); else pass_cnt++;
    chk_cnt++; if (io_grant_bits_data !== 64'd6 * STEP) $display("FAIL postrst_data got %h expected %h", io_grant_bits_data, 64'd6 * STEP); else pass_cnt++;
    pop_grant();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_put_get();
    test_partial_put();
    test_put_block();
    test_get_block();
    test_unsupported();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
